// File: rtl/exe_muldiv.sv
// +--------------------------------------------------------------------------+
// | exe_muldiv: iterative 32x32 multiply / 32/32 divide unit owning HI/LO    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module exe_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic [4:0]  count;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;

  logic        accept;
  logic        div_zero;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_step;
  logic [31:0] q_fix, r_fix;
  logic [63:0] result;

  always_comb begin
    accept   = start && !flush && (state == IDLE || state == DONE);
    div_zero = accept && op[1] && (operand_b == 32'd0);
    a_neg    = !op[0] && operand_a[31];
    b_neg    = !op[0] && operand_b[31];
    a_mag    = a_neg ? -operand_a : operand_a;
    b_mag    = b_neg ? -operand_b : operand_b;
  end

  // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_step = {mul_sum, acc[31:1]};
  end

  // Divide: the shifted partial remainder is 33 bits wide; the difference always fits in 32.
  always_comb begin
    div_ge   = {1'b0, acc[63:31]} >= {2'b00, opnd};
    div_rem  = acc[62:31] - opnd;
    div_step = div_ge ? {div_rem, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
  end

  always_comb begin
    q_fix  = neg_q ? -acc[31:0] : acc[31:0];
    r_fix  = neg_r ? -acc[63:32] : acc[63:32];
    result = is_div ? {r_fix, q_fix} : (neg_q ? -acc : acc);
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = div_zero ? DONE : CALC;
        CALC:    if (count == 5'd0) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = accept ? (div_zero ? DONE : CALC) : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= 64'd0;
      opnd        <= 32'd0;
      count       <= 5'd0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else if (!flush) begin
      if (accept) begin
        div_by_zero <= div_zero;
        if (div_zero) begin
          hi <= operand_a;
          lo <= 32'hFFFF_FFFF;
        end else begin
          is_div <= op[1];
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          count  <= 5'd31;
          acc    <= op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
          opnd   <= op[1] ? b_mag : a_mag;
        end
      end else if (state == CALC) begin
        acc   <= is_div ? div_step : mul_step;
        count <= count - 5'd1;
      end else if (state == FIX) begin
        hi <= result[63:32];
        lo <= result[31:0];
      end
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative multiply/divide unit in the EXE stage of the five-stage MIPS pipeline. It consumes the rs/rt operand values and decoded op held in the ID/EXE pipeline register, and produces the 64-bit HI/LO result. It computes one result bit per cycle and asserts `busy` so hazard control can freeze IF/ID/ID_EXE while an operation is in flight. HI/LO are architectural registers owned by this block and read by `mfhi`/`mflo`.

## Interface
Parameters:
- none (fixed 32-bit datapath, 32 iterations)

Ports:
- `clk`  in  1  pipeline clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  issue request; operands and op valid in the same cycle
- `op`  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- `operand_a`  in  32  rs value (multiplicand / dividend)
- `operand_b`  in  32  rt value (multiplier / divisor)
- `flush`  in  1  abort in-flight operation (branch/exception squash)
- `busy`  out  1  high in CALC and FIX; drives pipeline stall
- `done`  out  1  one-cycle pulse; HI/LO hold the new result
- `div_by_zero`  out  1  sticky per operation; set with `done` for DIV/DIVU with `operand_b == 0`
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE: `start` is accepted. Operands are latched. Signed ops latch magnitudes plus sign flags. Iteration counter is set to 31, then go to CALC. Otherwise DONE→IDLE, IDLE holds.
- `start` in CALC/FIX is ignored.
- Divisor zero on DIV/DIVU goes IDLE/DONE→DONE directly, skipping CALC/FIX. Result: `hi = operand_a`, `lo = 32'hFFFFFFFF`, `div_by_zero = 1`.
- CALC multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC divide: restoring division on a 64-bit {remainder, quotient} register, one quotient bit per cycle.
- CALC leaves to FIX after the counter-0 iteration (exactly 32 cycles).
- FIX, signed MULT: negate the 64-bit product if the operand signs differ.
- FIX, signed DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
- FIX, unsigned ops: result passes unchanged.
- DIV −2^31 / −1 wraps naturally: LO = 32'h80000000, HI = 0.
- FIX→DONE: HI/LO are written on this edge; LO = product[31:0] or quotient, HI = product[63:32] or remainder.
- DONE: `done = 1` for one cycle.
- `div_by_zero` is cleared on every accepted `start`.
- `flush`: at the next edge state → IDLE from any state, HI/LO and `div_by_zero` unchanged, no `done`. `flush` has priority over `start` in the same cycle.
- Reset: state IDLE, `hi = lo = 0`, `busy = done = div_by_zero = 0`, counter and internal registers 0. `rst` overrides `flush` and `start`.

## Timing
- `start` is sampled at edge E0.
- `busy` is high for cycles E0+1 … E0+33: 32 CALC cycles plus 1 FIX cycle.
- `done` is high in cycle E0+34, with the new HI/LO visible in the same cycle.
- Total latency from accepted start to `done` is 34 cycles.
- Divide-by-zero: `done` and the result are visible in cycle E0+1; `busy` never rises.
- Back-to-back: `start` during DONE is accepted. `busy` rises the next cycle, with no idle gap.
- HI/LO change only on the FIX→DONE edge, the div-by-zero edge, or reset.
- `busy` and `done` are registered outputs (decoded from state); there is no combinational path from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` at E0+34, HI = 0xFFFFFFFE, LO = 0x00000001, `busy` high for exactly 33 cycles.
- MULT −3 × 7, then back-to-back DIV −7 / 2 issued during DONE:
  - first result: HI = 0xFFFFFFFF, LO = 0xFFFFFFEB;
  - second result: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF;
  - `busy` has no gap between operations.
- DIVU 100 / 0 → `done` at E0+1, `div_by_zero = 1`, HI = 100, LO = 0xFFFFFFFF.
- Next DIVU 100 / 7 → `div_by_zero` cleared on start, then LO = 14, HI = 2.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MULTU 5 × 5 with `flush` at E0+10 → state IDLE at E0+11, no `done` pulse, HI/LO keep prior values.
- Synchronous `rst` at E0+20 mid-DIVU → all outputs 0 on the next edge.
- `start` during CALC is ignored.
